redstone_probe: RTL and testbench

- Observation port for the compiled redstone circuit: snapshots a bank of N component outputs (repeater/torch nets) on each game tick.
- Compares the snapshot with the previously reported state and streams one change event per net toggle to the host-side readout over a valid/ready interface.
- Sits between the component array and the host bridge. It is the reading end of the nets the components drive.

---
 rtl/redstone_pkg.sv | 27 ++
 rtl/redstone_probe_ffs.sv | 34 +++
 rtl/redstone_probe.sv | 134 +++++++++++++
 tb/tb_redstone_probe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/redstone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : redstone_pkg
//  Description : Shared types and defaults for the redstone I/O blocks:
//                default tick/index widths, the packed change-event record
//                and the probe scan state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package redstone_pkg;

    localparam int TICK_W_DEF = 32;
    localparam int IDX_W_DEF  = 5;

    // One reported net toggle as seen by the host bridge.
    typedef struct packed {
        logic [TICK_W_DEF-1:0] stamp;
        logic [IDX_W_DEF-1:0]  index;
        logic                  level;
    } probe_event_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } probe_state_t;

endpackage
`default_nettype wire

// File: rtl/redstone_probe_ffs.sv
`default_nettype none
// ============================================================================
//  Module      : probe_ffs
//  Description : Combinational find-first-set over an N-bit vector.
//  Ports       : i_vec  - vector to search
//                o_idx  - index of the lowest set bit (0 when none set)
//                o_any  - at least one bit of i_vec is set
//  Revision    : 1.0  initial release
// ============================================================================
module probe_ffs
    import redstone_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/redstone_probe.sv
`default_nettype none
// ============================================================================
//  Module      : redstone_probe
//  Description : Snapshots N component nets on each game tick, diffs against
//                the last reported state and streams one event per toggled
//                net (ascending index) over a valid/ready interface.
//  Ports       : i_clk, i_rst_n (async, active low)
//                i_tick        - capture strobe, nets stable on this edge
//                i_nets        - current component output levels
//                i_clr_overrun - clear sticky overrun flag
//                i_ready       - host accepts current event
//                o_valid/o_index/o_level/o_stamp - event payload
//                o_overrun     - sticky: a tick was coalesced
//                o_busy        - changes still pending
//  Revision    : 1.0  initial release
// ============================================================================
module redstone_probe
    import redstone_pkg::*;
#(
    parameter int           N      = 32,
    parameter int           IDX_W  = 5,
    parameter int           TICK_W = TICK_W_DEF,
    parameter logic [N-1:0] INIT   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic [N-1:0]      i_nets,
    input  logic              i_clr_overrun,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_level,
    output logic [TICK_W-1:0] o_stamp,
    output logic              o_overrun,
    output logic              o_busy
);

    probe_state_t      r_state;
    probe_state_t      w_state_nxt;
    logic [TICK_W-1:0] r_cnt;
    logic [TICK_W-1:0] r_stamp;
    logic [N-1:0]      r_snap;
    logic [N-1:0]      r_last;
    logic [N-1:0]      r_pend;
    logic              r_ovr;

    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_valid;
    logic              w_hs;
    logic [N-1:0]      w_pend_clr;
    logic              w_drained;
    logic              w_accept;
    logic [N-1:0]      w_base;
    logic [N-1:0]      w_diff;

    probe_ffs #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_ffs (
        .i_vec (r_pend),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_valid    = (r_state == ST_SCAN) & w_any;
    assign w_hs       = w_valid & i_ready;
    assign w_pend_clr = r_pend & ~(N'(1) << w_idx);
    // Final event of the scan is being taken on this edge.
    assign w_drained  = w_hs & ~(|w_pend_clr);
    assign w_accept   = i_tick & ((r_state == ST_IDLE) | w_drained);
    // When the scan completes on the capture edge, the snapshot just finished
    // becomes the reported state, so the new diff must be taken against it.
    assign w_base     = w_drained ? r_snap : r_last;
    assign w_diff     = i_nets ^ w_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = (|w_diff) ? ST_SCAN : ST_IDLE;
        end else if (w_drained) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_stamp <= '0;
            r_snap  <= '0;
            r_last  <= INIT;
            r_pend  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (i_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_drained) begin
                r_last <= r_snap;
            end
            if (w_accept) begin
                r_snap  <= i_nets;
                r_pend  <= w_diff;
                r_stamp <= r_cnt + 1'b1;
            end else if (w_hs) begin
                r_pend  <= w_pend_clr;
            end
            // A rejected tick sets overrun; set dominates a coincident clear.
            if (i_tick & ~w_accept) begin
                r_ovr <= 1'b1;
            end else if (i_clr_overrun) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign o_valid   = w_valid;
    assign o_index   = w_idx;
    assign o_level   = r_snap[w_idx];
    assign o_stamp   = r_stamp;
    assign o_overrun = r_ovr;
    assign o_busy    = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_redstone_probe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_redstone_probe
//  Description : Self-checking bench for redstone_probe (N=8, TICK_W=4).
//                Directed vector table, hand-written corner sequences and
//                randomized traffic against an event-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_redstone_probe;

    localparam int N      = 8;
    localparam int IDX_W  = 3;
    localparam int TICK_W = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_tick = 1'b0;
    logic [N-1:0]      i_nets = '0;
    logic              i_clr_overrun = 1'b0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [IDX_W-1:0]  o_index;
    logic              o_level;
    logic [TICK_W-1:0] o_stamp;
    logic              o_overrun;
    logic              o_busy;

    redstone_probe #(
        .N      (N),
        .IDX_W  (IDX_W),
        .TICK_W (TICK_W),
        .INIT   ('0)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_tick        (i_tick),
        .i_nets        (i_nets),
        .i_clr_overrun (i_clr_overrun),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_index       (o_index),
        .o_level       (o_level),
        .o_stamp       (o_stamp),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of events still owed to the host, the per-net
    // level the host has been told, a tick counter and the overrun flag.
    typedef struct {
        int idx;
        bit lvl;
        int stamp;
    } ev_t;

    ev_t q[$];
    bit  rep[N];
    int  m_cnt;
    bit  m_ovr;

    typedef struct {
        bit         t;
        logic [7:0] n;
        bit         r;
        bit         c;
        bit         ev;
        int         idx;
        bit         lvl;
        int         st;
        bit         ov;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) rep[i] = 1'b0;
        m_cnt = 0;
        m_ovr = 1'b0;
    endtask

    task automatic model_check();
        bit ev;
        ev = (q.size() != 0);
        chk("valid", int'(o_valid), int'(ev));
        chk("busy", int'(o_busy), int'(ev));
        chk("overrun", int'(o_overrun), int'(m_ovr));
        if (ev) begin
            chk("index", int'(o_index), q[0].idx);
            chk("level", int'(o_level), int'(q[0].lvl));
            chk("stamp", int'(o_stamp), q[0].stamp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit   set_ovr;
        ev_t  e;
        set_ovr = 1'b0;
        if (q.size() != 0 && i_ready) begin
            rep[q[0].idx] = q[0].lvl;
            q.delete(0);
        end
        if (i_tick) begin
            m_cnt = (m_cnt + 1) % (1 << TICK_W);
            if (q.size() == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i_nets[i] != rep[i]) begin
                        e.idx   = i;
                        e.lvl   = i_nets[i];
                        e.stamp = m_cnt;
                        q.push_back(e);
                    end
                end
            end else begin
                set_ovr = 1'b1;
            end
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (i_clr_overrun) m_ovr = 1'b0;
    endtask

    task automatic step(input bit t, input logic [N-1:0] n, input bit r, input bit c);
        i_tick        = t;
        i_nets        = n;
        i_ready       = r;
        i_clr_overrun = c;
        model_check();
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] nets;

        //               t  nets   r  c   ev idx lvl st  ov
        tbl[0]  = '{1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1, 1'b0};
        tbl[1]  = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1, 1'b0};
        tbl[2]  = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1, 1'b0};
        tbl[3]  = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 8'h25, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 8'h27, 1'b1, 1'b0, 1'b1, 1, 1'b1, 3, 1'b0};
        tbl[6]  = '{1'b0, 8'h27, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3, 1'b0};
        tbl[7]  = '{1'b0, 8'h27, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3, 1'b0};
        tbl[8]  = '{1'b0, 8'h27, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3, 1'b0};
        tbl[9]  = '{1'b0, 8'h27, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3, 1'b0};
        tbl[10] = '{1'b0, 8'h27, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};

        // Reset state
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_index", int'(o_index), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_stamp", int'(o_stamp), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_busy", int'(o_busy), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed vectors: basic scan, unchanged tick, host stall
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].t, tbl[k].n, tbl[k].r, tbl[k].c);
            chk($sformatf("tv%0d_valid", k), int'(o_valid), int'(tbl[k].ev));
            chk($sformatf("tv%0d_busy", k), int'(o_busy), int'(tbl[k].ev));
            chk($sformatf("tv%0d_overrun", k), int'(o_overrun), int'(tbl[k].ov));
            if (tbl[k].ev) begin
                chk($sformatf("tv%0d_index", k), int'(o_index), tbl[k].idx);
                chk($sformatf("tv%0d_level", k), int'(o_level), int'(tbl[k].lvl));
                chk($sformatf("tv%0d_stamp", k), int'(o_stamp), tbl[k].st);
            end
        end

        // Overrun and coalescing: net 3 pulses during rejected ticks
        step(1'b1, 8'h36, 1'b0, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b0);
        chk("ovr_set", int'(o_overrun), 1);
        step(1'b1, 8'h76, 1'b0, 1'b1);
        chk("ovr_set_beats_clr", int'(o_overrun), 1);
        chk("ovr_payload_idx", int'(o_index), 0);
        chk("ovr_payload_stamp", int'(o_stamp), 4);
        step(1'b0, 8'h76, 1'b1, 1'b0);
        step(1'b0, 8'h76, 1'b1, 1'b1);
        chk("ovr_cleared", int'(o_overrun), 0);
        step(1'b1, 8'h76, 1'b1, 1'b0);
        chk("coalesce_idx", int'(o_index), 6);
        chk("coalesce_stamp", int'(o_stamp), 7);

        // Tick coincident with final handshake
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("coinc_overrun", int'(o_overrun), 0);
        chk("coinc_valid", int'(o_valid), 1);
        chk("coinc_idx", int'(o_index), 0);
        chk("coinc_stamp", int'(o_stamp), 8);
        step(1'b0, 8'h77, 1'b1, 1'b0);

        // Counter wrap
        for (int k = 0; k < 6; k++) step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b1, 8'h67, 1'b1, 1'b0);
        chk("wrap_stamp15", int'(o_stamp), 15);
        step(1'b0, 8'h67, 1'b1, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        chk("wrap_stamp0", int'(o_stamp), 0);
        chk("wrap_idx", int'(o_index), 0);
        step(1'b0, 8'h66, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a scan
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h99, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_index", int'(o_index), 0);
        chk("mid_rst_level", int'(o_level), 0);
        chk("mid_rst_stamp", int'(o_stamp), 0);
        chk("mid_rst_overrun", int'(o_overrun), 0);
        model_reset();
        i_tick = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b0, 8'h99, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        chk("post_rst_stamp", int'(o_stamp), 1);

        // Randomized traffic against the model
        nets = 8'h01;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) nets = 8'($urandom);
            else if ($urandom_range(0, 2) == 0) nets = nets ^ (8'h01 << $urandom_range(0, 7));
            step($urandom_range(0, 2) == 0, nets,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        model_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
